// File: rtl/calc_req_tracker_if.sv
// Command, DUT-request, DUT-response and completion bundle for calc_req_tracker.
// master = command source / DUT model side, slave = the tracker itself.
interface calc_req_tracker_if #(
    parameter int NUM_PORTS = 4,
    parameter int CMD_W     = 4,
    parameter int TAG_W     = 2,
    parameter int DATA_W    = 32,
    parameter int LAT_W     = 8
);
    logic [NUM_PORTS-1:0]           in_valid;
    logic [NUM_PORTS-1:0]           in_ready;
    logic [NUM_PORTS*CMD_W-1:0]     in_cmd;
    logic [NUM_PORTS*DATA_W-1:0]    in_data;
    logic [NUM_PORTS*CMD_W-1:0]     req_cmd;
    logic [NUM_PORTS*TAG_W-1:0]     req_tag;
    logic [NUM_PORTS*DATA_W-1:0]    req_data;
    logic [NUM_PORTS*2-1:0]         out_resp;
    logic [NUM_PORTS*TAG_W-1:0]     out_tag;
    logic [NUM_PORTS*DATA_W-1:0]    out_data;
    logic [NUM_PORTS-1:0]           cpl_valid;
    logic [NUM_PORTS*TAG_W-1:0]     cpl_tag;
    logic [NUM_PORTS*2-1:0]         cpl_resp;
    logic [NUM_PORTS*DATA_W-1:0]    cpl_data;
    logic [NUM_PORTS*LAT_W-1:0]     cpl_lat;
    logic [NUM_PORTS-1:0]           err_unexp;
    logic [NUM_PORTS-1:0]           err_timeout;
    logic [NUM_PORTS*(TAG_W+1)-1:0] busy_cnt;

    modport master (
        output in_valid, in_cmd, in_data, out_resp, out_tag, out_data,
        input  in_ready, req_cmd, req_tag, req_data, cpl_valid, cpl_tag, cpl_resp,
               cpl_data, cpl_lat, err_unexp, err_timeout, busy_cnt
    );

    modport slave (
        input  in_valid, in_cmd, in_data, out_resp, out_tag, out_data,
        output in_ready, req_cmd, req_tag, req_data, cpl_valid, cpl_tag, cpl_resp,
               cpl_data, cpl_lat, err_unexp, err_timeout, busy_cnt
    );
endinterface

// File: rtl/calc_req_tracker.sv
// Per-port request issuer and tag tracker with latency measurement for CALC-family DUTs.
// Optional tag timeout is built when CALC_TRK_TIMEOUT_EN is defined.
module calc_req_tracker #(
    parameter int NUM_PORTS = 4,
    parameter int CMD_W     = 4,
    parameter int TAG_W     = 2,
    parameter int DATA_W    = 32,
    parameter int LAT_W     = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic               c_clk,
    input  logic               reset,
    calc_req_tracker_if.slave  bus
);
    localparam int              NUM_TAGS = 2 ** TAG_W;
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    // Holds in_ready low until the first clock after reset is released.
    logic ready_en_reg;

    always_ff @(posedge c_clk) begin
        if (!reset) ready_en_reg <= 1'b0;
        else        ready_en_reg <= 1'b1;
    end

`ifndef CALC_TRK_TIMEOUT_EN
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            logic [CMD_W-1:0]    cmd;
            logic [DATA_W-1:0]   data;
            logic [1:0]          resp;
            logic [TAG_W-1:0]    rsp_tag;
            logic [DATA_W-1:0]   rsp_data;
            logic [NUM_TAGS-1:0] busy_reg;
            logic [NUM_TAGS-1:0] busy_next;
            logic [NUM_TAGS-1:0] expire;
            logic [LAT_W-1:0]    age_reg [NUM_TAGS];
            logic [LAT_W-1:0]    age_now [NUM_TAGS];
            logic [TAG_W-1:0]    free_tag;
            logic                ready;
            logic                issue;
            logic                rsp_hit;
            logic                rsp_miss;

            logic [CMD_W-1:0]    req_cmd_reg;
            logic [TAG_W-1:0]    req_tag_reg;
            logic [DATA_W-1:0]   req_data_reg;
            logic                cpl_valid_reg;
            logic [TAG_W-1:0]    cpl_tag_reg;
            logic [1:0]          cpl_resp_reg;
            logic [DATA_W-1:0]   cpl_data_reg;
            logic [LAT_W-1:0]    cpl_lat_reg;
            logic                err_unexp_reg;

            assign cmd      = bus.in_cmd[gi*CMD_W +: CMD_W];
            assign data     = bus.in_data[gi*DATA_W +: DATA_W];
            assign resp     = bus.out_resp[gi*2 +: 2];
            assign rsp_tag  = bus.out_tag[gi*TAG_W +: TAG_W];
            assign rsp_data = bus.out_data[gi*DATA_W +: DATA_W];

            assign ready    = ready_en_reg & ~(&busy_reg);
            assign issue    = bus.in_valid[gi] & ready & (cmd != '0);
            assign rsp_hit  = (resp != 2'd0) &  busy_reg[rsp_tag];
            assign rsp_miss = (resp != 2'd0) & ~busy_reg[rsp_tag];

            // age_now is the age as seen at the coming edge, i.e. cycles since the issue edge.
            always_comb begin
                free_tag = '0;
                for (int t = NUM_TAGS - 1; t >= 0; t--) begin
                    if (!busy_reg[t]) free_tag = TAG_W'(t);
                end
                for (int t = 0; t < NUM_TAGS; t++) begin
                    age_now[t] = (age_reg[t] == LAT_MAX) ? LAT_MAX : age_reg[t] + 1'b1;
                end
            end

`ifdef CALC_TRK_TIMEOUT_EN
            logic err_timeout_reg;

            // A response arriving on the expiry edge takes precedence over the timeout.
            always_comb begin
                expire = '0;
                for (int t = 0; t < NUM_TAGS; t++) begin
                    expire[t] = busy_reg[t] && (age_now[t] == LAT_W'(TIMEOUT))
                                && !(rsp_hit && (rsp_tag == TAG_W'(t)));
                end
            end

            always_ff @(posedge c_clk) begin
                if (!reset) err_timeout_reg <= 1'b0;
                else        err_timeout_reg <= |expire;
            end

            assign bus.err_timeout[gi] = err_timeout_reg;
`else
            assign expire              = '0;
            assign bus.err_timeout[gi] = 1'b0;
`endif

            always_comb begin
                busy_next = busy_reg & ~expire;
                if (rsp_hit) busy_next[rsp_tag]  = 1'b0;
                if (issue)   busy_next[free_tag] = 1'b1;
            end

            always_ff @(posedge c_clk) begin
                if (!reset) begin
                    busy_reg      <= '0;
                    req_cmd_reg   <= '0;
                    req_tag_reg   <= '0;
                    req_data_reg  <= '0;
                    cpl_valid_reg <= 1'b0;
                    cpl_tag_reg   <= '0;
                    cpl_resp_reg  <= '0;
                    cpl_data_reg  <= '0;
                    cpl_lat_reg   <= '0;
                    err_unexp_reg <= 1'b0;
                    for (int t = 0; t < NUM_TAGS; t++) age_reg[t] <= '0;
                end else begin
                    busy_reg <= busy_next;
                    for (int t = 0; t < NUM_TAGS; t++) begin
                        if (issue && (free_tag == TAG_W'(t))) age_reg[t] <= '0;
                        else if (busy_reg[t])                 age_reg[t] <= age_now[t];
                    end
                    req_cmd_reg   <= issue ? cmd : '0;
                    req_tag_reg   <= issue ? free_tag : '0;
                    req_data_reg  <= issue ? data : '0;
                    cpl_valid_reg <= rsp_hit;
                    cpl_tag_reg   <= rsp_hit ? rsp_tag : '0;
                    cpl_resp_reg  <= rsp_hit ? resp : '0;
                    cpl_data_reg  <= rsp_hit ? rsp_data : '0;
                    cpl_lat_reg   <= rsp_hit ? age_now[rsp_tag] : '0;
                    err_unexp_reg <= rsp_miss;
                end
            end

            assign bus.in_ready[gi]                          = ready;
            assign bus.req_cmd[gi*CMD_W +: CMD_W]            = req_cmd_reg;
            assign bus.req_tag[gi*TAG_W +: TAG_W]            = req_tag_reg;
            assign bus.req_data[gi*DATA_W +: DATA_W]         = req_data_reg;
            assign bus.cpl_valid[gi]                         = cpl_valid_reg;
            assign bus.cpl_tag[gi*TAG_W +: TAG_W]            = cpl_tag_reg;
            assign bus.cpl_resp[gi*2 +: 2]                   = cpl_resp_reg;
            assign bus.cpl_data[gi*DATA_W +: DATA_W]         = cpl_data_reg;
            assign bus.cpl_lat[gi*LAT_W +: LAT_W]            = cpl_lat_reg;
            assign bus.err_unexp[gi]                         = err_unexp_reg;
            assign bus.busy_cnt[gi*(TAG_W+1) +: (TAG_W+1)]   = (TAG_W+1)'($countones(busy_reg));
        end
    endgenerate
endmodule

// File: doc/calc_req_tracker.md
Name: calc_req_tracker

Overview:
- Parametrised, synthesizable request issuer and tag tracker for CALC-family DUTs with NUM_PORTS request/response channels.
- Accepts commands per port over a valid/ready handshake, allocates a free tag and drives the DUT-side reqN_cmd_in/tag/data pins.
- Matches out_resp/out_tag responses to outstanding tags and reports completions with measured latency.
- Flags unexpected responses and, optionally, timeouts. Replaces fixed 4-port, 2-bit-tag bench driving with a reusable block.

Parameters:
NUM_PORTS, 4, number of request/response channels
CMD_W, 4, command width; cmd value 0 means idle
TAG_W, 2, tag width; 2**TAG_W tags per port
DATA_W, 32, operand/result width
LAT_W, 8, latency counter width; saturates at all-ones
TIMEOUT, 200, cycles before an outstanding tag is declared lost (timeout feature only)

Ports:
c_clk  in  1  clock; all logic on posedge
reset  in  1  synchronous active-low reset
in_valid  in  NUM_PORTS  per-port command valid
in_ready  out  NUM_PORTS  per-port command ready
in_cmd  in  NUM_PORTS*CMD_W  command; port p at [p*CMD_W +: CMD_W]
in_data  in  NUM_PORTS*DATA_W  operand data
req_cmd  out  NUM_PORTS*CMD_W  to DUT reqN_cmd_in
req_tag  out  NUM_PORTS*TAG_W  to DUT reqN_tag_in
req_data  out  NUM_PORTS*DATA_W  to DUT reqN_data_in
out_resp  in  NUM_PORTS*2  from DUT; 0 means no response
out_tag  in  NUM_PORTS*TAG_W  from DUT
out_data  in  NUM_PORTS*DATA_W  from DUT
cpl_valid  out  NUM_PORTS  one-cycle completion pulse
cpl_tag  out  NUM_PORTS*TAG_W  completed tag
cpl_resp  out  NUM_PORTS*2  response code
cpl_data  out  NUM_PORTS*DATA_W  result data
cpl_lat  out  NUM_PORTS*LAT_W  cycles from issue to response
err_unexp  out  NUM_PORTS  pulse: response on a tag not outstanding
err_timeout  out  NUM_PORTS  pulse: tag aged out
busy_cnt  out  NUM_PORTS*(TAG_W+1)  outstanding tags per port

Behaviour:
- Reset (reset==0 at posedge): all tags free, all outputs 0, including req_cmd, cpl_*, err_*, busy_cnt and in_ready. in_ready rises in the first cycle after reset deasserts. Reset mid-operation drops all outstanding tags silently; responses arriving later raise err_unexp.
- in_ready[p] = at least one free tag on port p, computed from registered busy bits only. A tag freed in cycle t is allocatable from cycle t+1.
- Issue: handshake at posedge t with in_cmd!=0. The lowest-index free tag is allocated. At t+1, req_cmd/tag/data hold the command for exactly one cycle; req_cmd returns to 0 at t+2 unless another issue occurs. Back-to-back issue is allowed every cycle.
- Handshake with in_cmd==0 is consumed, allocates nothing and drives nothing.
- Per-tag age counter starts at 0 on issue and increments each cycle, saturating at 2**LAT_W-1.
- Response: out_resp[p]!=0 at posedge t.
  - Tag outstanding: at t+1, cpl_valid=1 with cpl_tag, cpl_resp, cpl_data and cpl_lat = age at t. The tag is freed at t+1.
  - Tag not outstanding: err_unexp pulses at t+1; no completion.
- Issue and response on the same port and cycle are both honoured. busy_cnt nets to the unchanged value.
- Ports are fully independent; no cross-port arbitration.

Optional Feature:
- Macro CALC_TRK_TIMEOUT_EN.
- Defined: when a tag's age reaches TIMEOUT, err_timeout pulses for one cycle and the tag is freed. A late response to that tag then raises err_unexp.
  - If a valid response and the timeout occur in the same cycle, the response wins: completion is reported, no timeout.
- Undefined: no timeout logic; err_timeout tied to 0; tags stay outstanding until a response arrives.

Test Plan:
- Reset with all inputs active, then release -> all outputs 0 during reset; in_ready=4'b1111 one cycle after release.
- Port 0: issue cmd=1, data=5, then DUT returns resp=1, tag=0, data=12 three cycles after req_cmd -> req_tag=0; cpl_valid pulse with cpl_data=12, cpl_lat=3; busy_cnt returns to 0.
- Port 2: issue 4 commands back-to-back -> tags 0,1,2,3 in order; in_ready[2]=0. Respond to tag 1 -> in_ready[2]=1 the next cycle; next issue reuses tag 1.
- Port 1: response tag=2 with nothing outstanding -> err_unexp[1] pulse; cpl_valid[1] stays 0.
- Issue on port 3 in the same cycle as a response for port 3 tag 0 -> both handled; busy_cnt[3] unchanged.
- With CALC_TRK_TIMEOUT_EN and TIMEOUT=10: issue, no response -> err_timeout pulse 10 cycles after issue; tag freed. A later response to it -> err_unexp.
